// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if
// Purpose : bundles the write/read handshake, data and status flags of the
//           router packet FIFO so the FIFO and its users connect through one
//           port. clock, reset and soft_reset stay as plain module ports.
// Signals : write_enb, read_enb, lfd_state, data_in   - requester -> FIFO
//           data_out, empty, full, almost_full,
//           fill_level, pkt_busy, pkt_done, overflow  - FIFO -> requester
// Modports: master (requester side), slave (FIFO side).
interface router_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic                  write_enb;
  logic                  read_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [FW-1:0]         fill_level;
  logic                  pkt_busy;
  logic                  pkt_done;
  logic                  overflow;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, empty, full, almost_full, fill_level,
           pkt_busy, pkt_done, overflow
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, empty, full, almost_full, fill_level,
           pkt_busy, pkt_done, overflow
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Purpose : single-clock packet FIFO for a router output port. Each entry
//           holds a data byte plus a header tag. A packet counter tracks how
//           many payload+parity bytes of the current packet are still to be
//           read, driving pkt_busy and a pkt_done pulse after the parity byte.
// Ports   : clock      - rising-edge clock
//           reset      - asynchronous active-high reset (clears all state)
//           soft_reset - synchronous active-high flush
//           bus        - router_pkt_fifo_if.slave (handshake, data, flags)
module router_pkt_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic              clock,
  input logic              reset,
  input logic              soft_reset,
  router_pkt_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = DATA_WIDTH - 1;

  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  // Storage: data bits are never reset; the header tags are.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      tag_r;

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         pkt_cnt_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  pkt_done_r;
  logic                  overflow_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  almost_full_s;
  logic [PW-1:0]         fill_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] rd_entry_s;
  logic                  rd_tag_s;
  logic [CW-1:0]         len_s;
  logic [CW-1:0]         cnt_nxt_s;
  logic                  done_nxt_s;

  // Occupancy flags and accept decisions, all from registered pointers.
  always_comb begin
    empty_s       = (wr_ptr_r == rd_ptr_r);
    full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    fill_s        = wr_ptr_r - rd_ptr_r;
    almost_full_s = (fill_s >= AFULL_LVL);
    wr_acc_s      = bus.write_enb && !full_s;
    rd_acc_s      = bus.read_enb && !empty_s;
    rd_entry_s    = mem_r[rd_ptr_r[AW-1:0]];
    rd_tag_s      = tag_r[rd_ptr_r[AW-1:0]];
    // Header length field sits above the two low bits; +1 covers parity.
    len_s         = {1'b0, rd_entry_s[DATA_WIDTH-1:2]} + CNT_ONE;
  end

  // Packet counter next state: tagged read (re)loads, untagged read counts
  // down, and only the 1->0 step produces pkt_done.
  always_comb begin
    cnt_nxt_s  = pkt_cnt_r;
    done_nxt_s = 1'b0;
    if (rd_acc_s) begin
      if (rd_tag_s) begin
        cnt_nxt_s = len_s;
      end else if (pkt_cnt_r != CNT_ZERO) begin
        cnt_nxt_s  = pkt_cnt_r - CNT_ONE;
        done_nxt_s = (pkt_cnt_r == CNT_ONE);
      end else begin
        cnt_nxt_s = pkt_cnt_r;
      end
    end else begin
      cnt_nxt_s = pkt_cnt_r;
    end
  end

  // Control state: pointers, tags, counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      tag_r      <= {DEPTH{1'b0}};
      pkt_cnt_r  <= CNT_ZERO;
      data_out_r <= {DATA_WIDTH{1'b0}};
      pkt_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      tag_r      <= {DEPTH{1'b0}};
      pkt_cnt_r  <= CNT_ZERO;
      data_out_r <= {DATA_WIDTH{1'b0}};
      pkt_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r                  <= wr_ptr_r + PTR_ONE;
        tag_r[wr_ptr_r[AW-1:0]]   <= bus.lfd_state;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // data_out returns to zero whenever no read was accepted.
      data_out_r <= rd_acc_s ? rd_entry_s : {DATA_WIDTH{1'b0}};
      pkt_cnt_r  <= cnt_nxt_s;
      pkt_done_r <= done_nxt_s;
      if (bus.write_enb && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Data array write port; a soft flush suppresses the concurrent write.
  always_ff @(posedge clock) begin
    if (wr_acc_s && !soft_reset) begin
      mem_r[wr_ptr_r[AW-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = almost_full_s;
  assign bus.fill_level  = fill_s;
  assign bus.pkt_busy    = (pkt_cnt_r != CNT_ZERO);
  assign bus.pkt_done    = pkt_done_r;
  assign bus.overflow    = overflow_r;

endmodule
